timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_pkg.sv | 14 +
 rtl/timer_ctrl_count.sv | 23 ++
 rtl/timer_ctrl.sv | 115 +++++++++++
 tb/tb_timer_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state encodings and mode constants for timer_ctrl
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } timer_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_count.sv
// rtl/timer_ctrl_count.sv - N-bit clearable, enabled up-counter with async reset
module timer_count #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] q
);

    // clr wins over en so a wrap or abort never sees a stray increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - one-shot/periodic timer FSM with pause, stop and terminal-count decode
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         mode,
    input  logic [N-1:0] limit,
    output logic [N-1:0] q,
    output logic         tick,
    output logic         done,
    output logic         busy
);

    timer_state_t state;
    timer_state_t next_state;
    logic [N-1:0] limit_r;
    logic         mode_r;
    logic         cnt_clr;
    logic         cnt_en;
    logic         load;
    logic         at_limit;

    assign at_limit = (q == limit_r);

    timer_count #(.N(N)) u_count (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (q)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Run parameters are captured only when a run starts, so mid-run changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limit_r <= '0;
            mode_r  <= MODE_ONESHOT;
        end else if (load) begin
            limit_r <= limit;
            mode_r  <= mode;
        end
    end

    // Next-state and counter control; stop outranks pause, which outranks counting
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    next_state = RUN;
                    cnt_clr    = 1'b1;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
                    cnt_clr    = 1'b1;
                end else if (pause) begin
                    next_state = HOLD;
                end else if (at_limit) begin
                    if (mode_r == MODE_PERIODIC) begin
                        cnt_clr = 1'b1;
                    end else begin
                        next_state = DONE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    next_state = IDLE;
                    cnt_clr    = 1'b1;
                end else if (!pause) begin
                    next_state = RUN;
                end
            end
            DONE: begin
                next_state = IDLE;
                cnt_clr    = 1'b1;
            end
            default: begin
                next_state = IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    // Output decode from registered state; stop masks both tick and done in its cycle
    always_comb begin
        tick = (state == RUN) && !pause && !stop && at_limit;
        done = (state == DONE) && !stop;
        busy = (state == RUN) || (state == HOLD);
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed self-checking bench for timer_ctrl
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       mode;
    logic [3:0] limit;
    logic [3:0] q;
    logic       tick;
    logic       done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    timer_ctrl #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .pause (pause),
        .mode  (mode),
        .limit (limit),
        .q     (q),
        .tick  (tick),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eq, input logic et,
                           input logic ed, input logic eb);
        #1;
        chk({tag, ".q"},    q,    eq);
        chk({tag, ".tick"}, tick, et);
        chk({tag, ".done"}, done, ed);
        chk({tag, ".busy"}, busy, eb);
    endtask

    logic [3:0] pq [1:10];

    initial begin
        pq = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; limit = 4'd0;
        #12;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // One-shot, limit 3, with start re-pulsed mid-run and in DONE, limit changed mid-run
        cyc();
        start = 1'b1; mode = 1'b0; limit = 4'd3;
        cyc();
        start = 1'b0; limit = 4'd7; mode = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            start = (c == 2);
            chk_all($sformatf("os3.c%0d", c), 4'(c - 1), c == 4, 1'b0, 1'b1);
            cyc();
        end
        start = 1'b1;
        chk_all("os3.c5", 4'd3, 1'b0, 1'b1, 1'b0);
        cyc();
        start = 1'b0;
        chk_all("os3.c6", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk_all("os3.c7", 4'd0, 1'b0, 1'b0, 1'b0);

        // Periodic, limit 2, stopped in cycle 10
        start = 1'b1; mode = 1'b1; limit = 4'd2;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk_all($sformatf("per2.c%0d", c), 4'((c - 1) % 3), (c % 3) == 0, 1'b0, 1'b1);
            cyc();
        end
        stop = 1'b1;
        chk_all("per2.stop", 4'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        stop = 1'b0;
        chk_all("per2.idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // One-shot, limit 5, pause high in cycles 2-4
        start = 1'b1; mode = 1'b0; limit = 4'd5;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            pause = (c >= 2 && c <= 4);
            chk_all($sformatf("pause.c%0d", c), pq[c], c == 10, 1'b0, 1'b1);
            cyc();
        end
        pause = 1'b0;
        chk_all("pause.done", 4'd5, 1'b0, 1'b1, 1'b0);
        cyc();
        chk_all("pause.idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // Pause on a would-be tick cycle suppresses it; tick follows once resumed
        start = 1'b1; mode = 1'b0; limit = 4'd1;
        cyc();
        start = 1'b0;
        cyc();
        pause = 1'b1;
        chk_all("ptick.sup", 4'd1, 1'b0, 1'b0, 1'b1);
        cyc();
        pause = 1'b0;
        chk_all("ptick.hold", 4'd1, 1'b0, 1'b0, 1'b1);
        cyc();
        chk_all("ptick.run", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc();
        chk_all("ptick.done", 4'd1, 1'b0, 1'b1, 1'b0);
        cyc();

        // Stop in cycle 5 with limit 9, then start+stop together in IDLE
        start = 1'b1; mode = 1'b0; limit = 4'd9;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) cyc();
        stop = 1'b1;
        chk_all("stop.c5", 4'd4, 1'b0, 1'b0, 1'b1);
        cyc();
        start = 1'b1;
        chk_all("stop.c6", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        start = 1'b0; stop = 1'b0;
        chk_all("ststop", 4'd0, 1'b0, 1'b0, 1'b0);

        // One-shot, limit 0
        start = 1'b1; mode = 1'b0; limit = 4'd0;
        cyc();
        start = 1'b0;
        chk_all("os0.c1", 4'd0, 1'b1, 1'b0, 1'b1);
        cyc();
        chk_all("os0.c2", 4'd0, 1'b0, 1'b1, 1'b0);
        cyc();

        // Periodic, limit 0 ticks every cycle
        start = 1'b1; mode = 1'b1; limit = 4'd0;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk_all($sformatf("per0.c%0d", c), 4'd0, 1'b1, 1'b0, 1'b1);
            cyc();
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // Periodic, limit 15: full range then back to 0
        start = 1'b1; mode = 1'b1; limit = 4'd15;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c >= 15) chk_all($sformatf("per15.c%0d", c), 4'((c - 1) % 16), c == 16, 1'b0, 1'b1);
            cyc();
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // Async reset mid-cycle while q=3, then start on the first edge after release
        start = 1'b1; mode = 1'b0; limit = 4'd9;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) cyc();
        chk_all("rst.pre", 4'd3, 1'b0, 1'b0, 1'b1);
        #1;
        reset = 1'b1;
        chk_all("rst.mid", 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        start = 1'b1; mode = 1'b0; limit = 4'd2;
        cyc();
        start = 1'b0;
        chk_all("rst.start", 4'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        cyc();
        chk_all("rst.tick", 4'd2, 1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
